// File: rtl/lfsr_pkg.sv
// Shared types and defaults for the LFSR sequencer: state encoding, default width/taps
// and the maximal period used by the optional period checker.
package lfsr_pkg;

    localparam int         LFSR_W_DEF = 4;
    localparam logic [3:0] TAPS_DEF   = 4'b1100;
    localparam int         CNT_W_DEF  = 5;

    // Maximal-length period for the default width.
    localparam int PERIOD = (1 << LFSR_W_DEF) - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register: load has priority over step; shifts left, feedback into bit 0.
// One-cycle update, no internal backpressure (the caller gates step).
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int           W    = LFSR_W_DEF,
    parameter logic [W-1:0] TAPS = TAPS_DEF
) (
    input  logic         clkslow,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] seed,
    output logic [W-1:0] q
);

    always_ff @(posedge clkslow or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= seed;
        end else if (step) begin
            q <= {q[W-2:0], ^(q & TAPS)};
        end
    end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Sequences an lfsr_core: start loads seed, words stream out on valid/ready (1-cycle start latency,
// LFSR only steps on a transfer). Optional period checker: LFSR_SEQ_CTRL_PERIOD_CHK_EN.
module lfsr_seq_ctrl
    import lfsr_pkg::*;
#(
    parameter int           W     = LFSR_W_DEF,
    parameter logic [W-1:0] TAPS  = TAPS_DEF,
    parameter int           CNT_W = CNT_W_DEF
) (
    input  logic             clkslow,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     seed,
    input  logic [CNT_W-1:0] count,
    input  logic             stop,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             err_zero_seed
`ifdef LFSR_SEQ_CTRL_PERIOD_CHK_EN
    ,
    output logic             period_err
`endif
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] remaining;
    logic [W-1:0]     q;
    logic             load;
    logic             xfer;
    logic             err_nxt;

    assign xfer      = (state == RUN) && out_ready;
    assign out_valid = (state == RUN);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign out_data  = q;

    lfsr_core #(
        .W    (W),
        .TAPS (TAPS)
    ) u_core (
        .clkslow (clkslow),
        .rst     (rst),
        .load    (load),
        .step    (xfer),
        .seed    (seed),
        .q       (q)
    );

    always_ff @(posedge clkslow or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (seed != '0) begin
                        load      = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                // A final transfer completes the run even if stop arrives with it.
                if (xfer && (remaining == CNT_W'(1))) begin
                    state_nxt = DONE;
                end else if (stop) begin
                    state_nxt = IDLE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // remaining stays 0 in free-run mode, so the completion compare never matches.
    always_ff @(posedge clkslow or negedge rst) begin
        if (!rst) begin
            remaining     <= '0;
            err_zero_seed <= 1'b0;
        end else begin
            err_zero_seed <= err_nxt;
            if (load) begin
                remaining <= count;
            end else if (xfer && (remaining != '0)) begin
                remaining <= remaining - 1'b1;
            end
        end
    end

`ifdef LFSR_SEQ_CTRL_PERIOD_CHK_EN
    localparam logic [W-1:0] PERIOD_CNT = {W{1'b1}};

    logic [W-1:0] seed_q;
    logic [W-1:0] step_cnt;

    // Counter restarts on every return to the seed so long free-runs never wrap it.
    always_ff @(posedge clkslow or negedge rst) begin
        if (!rst) begin
            seed_q     <= '0;
            step_cnt   <= '0;
            period_err <= 1'b0;
        end else if (load) begin
            seed_q     <= seed;
            step_cnt   <= '0;
            period_err <= 1'b0;
        end else if (state == RUN) begin
            if ((step_cnt != '0) && (q == seed_q)) begin
                if (step_cnt != PERIOD_CNT) begin
                    period_err <= 1'b1;
                end
                step_cnt <= xfer ? {{(W-1){1'b0}}, 1'b1} : '0;
            end else if (xfer) begin
                step_cnt <= step_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
